// File: rtl/seq_mult_arbiter.sv
// Round-robin arbiter sharing one 4-bit sequential multiplier among NREQ
// requesters, with a watchdog that aborts a multiply whose done never comes.
// Ports:
//   clk, rst               clock, async active-high reset
//   req, a_in, b_in        per-requester request level and packed operands
//   gnt, result, result_valid, result_id, err
//                          one-cycle completion bundle in RESP
//   busy                   high outside IDLE
//   mul_start, mul_a, mul_b, mul_z, mul_done
//                          multiplier handshake
module seq_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        result,
    output logic              result_valid,
    output logic [1:0]        result_id,
    output logic              err,
    output logic              busy,
    output logic              mul_start,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    input  logic [7:0]        mul_z,
    input  logic              mul_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0] r_ptr;
    logic [1:0] r_id;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [7:0] r_cnt;
    logic [7:0] r_result;
    logic       r_err;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [1:0]        w_off;
    logic [2:0]        w_sum;
    logic [1:0]        w_sel;
    logic              w_any;
    logic [4*NREQ-1:0] w_a_sh;
    logic [4*NREQ-1:0] w_b_sh;
    logic              w_timeout;

    // Rotate req so bit 0 is the requester at ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner's offset.
    assign w_dbl = {req, req} >> r_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 2'(k);
            end
        end
    end

    assign w_any = |req;

    // ptr and offset are both below NREQ, so one subtraction wraps.
    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel = (w_sum >= 3'(NREQ)) ? 2'(w_sum - 3'(NREQ))
                                       : w_sum[1:0];

    assign w_a_sh = a_in >> {w_sel, 2'b00};
    assign w_b_sh = b_in >> {w_sel, 2'b00};

    assign w_timeout = (r_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (mul_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id <= w_sel;
                        r_a  <= w_a_sh[3:0];
                        r_b  <= w_b_sh[3:0];
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (mul_done) begin
                        r_result <= mul_z;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_id == 2'(NREQ - 1)) ? 2'd0
                                                    : r_id + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        gnt          = '0;
        result       = '0;
        result_valid = 1'b0;
        result_id    = '0;
        err          = 1'b0;
        if (r_state == S_RESP) begin
            gnt[r_id]    = 1'b1;
            result       = r_result;
            result_valid = 1'b1;
            result_id    = r_id;
            err          = r_err;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mul_start = (r_state == S_ISSUE);
    assign mul_a     = r_a;
    assign mul_b     = r_b;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Directed bench for seq_mult_arbiter with a behavioural multiplier stub
// (fixed latency, done can be suppressed to exercise the watchdog).
module tb_seq_mult_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic [7:0]  result;
    logic        result_valid;
    logic [1:0]  result_id;
    logic        err;
    logic        busy;
    logic        mul_start;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_z;
    logic        mul_done;

    logic        done_en;
    int          m_cnt;
    int          n_start;
    int          n_tests;
    int          n_fail;
    int          n;

    seq_mult_arbiter #(.NREQ(4), .TIMEOUT(31)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .gnt          (gnt),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .err          (err),
        .busy         (busy),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_z        (mul_z),
        .mul_done     (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stub: done pulses for one cycle, 4 cycles after start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            mul_done <= 1'b0;
            mul_z    <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                mul_z <= 8'(mul_a) * 8'(mul_b);
                m_cnt <= 3;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) mul_done <= done_en;
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start) n_start = n_start + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (gnt == 4'b0 && cnt < 60);
        chk("gnt_arrives", {31'b0, |gnt}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_start = 0;
        rst     = 1'b1;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        done_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", mul_start, 1'b0);
        chk("rst_mula", mul_a, 4'd0);
        chk("rst_rv", result_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single request 3*5
        req     = 4'b0001;
        a_in    = 16'h0003;
        b_in    = 16'h0005;
        n_start = 0;
        @(negedge clk);
        chk("a_start", mul_start, 1'b1);
        chk("a_busy", busy, 1'b1);
        chk("a_mula", mul_a, 4'd3);
        chk("a_mulb", mul_b, 4'd5);
        wait_gnt(n);
        chk("a_latency", n, 5);
        chk("a_gnt", gnt, 4'b0001);
        chk("a_res", result, 8'd15);
        chk("a_rv", result_valid, 1'b1);
        chk("a_id", result_id, 2'd0);
        chk("a_err", err, 1'b0);
        chk("a_nstart", n_start, 1);
        req = '0;
        @(negedge clk);
        chk("a_gnt_off", gnt, 4'b0);
        chk("a_rv_off", result_valid, 1'b0);
        chk("a_res_off", result, 8'd0);
        chk("a_idle", busy, 1'b0);

        // Two simultaneous requests
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b0101;
        a_in = 16'h0F02;
        b_in = 16'h0F07;
        wait_gnt(n);
        chk("b_gnt0", gnt, 4'b0001);
        chk("b_res0", result, 8'd14);
        req = 4'b0100;
        wait_gnt(n);
        chk("b_gnt2", gnt, 4'b0100);
        chk("b_res2", result, 8'hE1);
        chk("b_id2", result_id, 2'd2);

        // All four held: rotation 0,1,2,3,0,1,2,3
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        a_in = 16'h4321;
        b_in = 16'h2222;
        req  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] eg[4];
            logic [7:0] er[4];
            eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
            er = '{8'd2, 8'd4, 8'd6, 8'd8};
            wait_gnt(n);
            chk($sformatf("rr_gnt%0d", k), gnt, eg[k%4]);
            chk($sformatf("rr_res%0d", k), result, er[k%4]);
        end
        req = '0;

        // Watchdog abort, then a normal completion
        done_en = 1'b0;
        @(negedge clk);
        req  = 4'b0010;
        a_in = 16'h0040;
        b_in = 16'h0040;
        wait_gnt(n);
        chk("to_latency", n, 34);
        chk("to_gnt", gnt, 4'b0010);
        chk("to_res", result, 8'd0);
        chk("to_err", err, 1'b1);
        done_en = 1'b1;
        wait_gnt(n);
        chk("to_next_res", result, 8'd16);
        chk("to_next_err", err, 1'b0);

        // Reset during WAIT of requester 1 (ptr is 2 here)
        a_in = 16'h3050;
        b_in = 16'h2060;
        repeat (3) @(negedge clk);
        chk("r_wait_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("r_gnt", gnt, 4'b0);
        chk("r_busy", busy, 1'b0);
        chk("r_start", mul_start, 1'b0);
        chk("r_mula", mul_a, 4'd0);
        chk("r_mulb", mul_b, 4'd0);
        chk("r_rv", result_valid, 1'b0);
        chk("r_res", result, 8'd0);
        req = 4'b1010;
        @(negedge clk);
        rst = 1'b0;
        wait_gnt(n);
        chk("r_gnt1", gnt, 4'b0010);
        chk("r_res1", result, 8'd30);
        req = 4'b1000;
        wait_gnt(n);
        chk("r_gnt3", gnt, 4'b1000);
        chk("r_res3", result, 8'd6);
        req = '0;

        // Zero operand and operand stability during WAIT
        @(negedge clk);
        a_in = 16'h0000;
        b_in = 16'h0009;
        req  = 4'b0001;
        @(negedge clk);
        chk("s_start", mul_start, 1'b1);
        chk("s_mula0", mul_a, 4'd0);
        chk("s_mulb0", mul_b, 4'd9);
        @(negedge clk);
        a_in = 16'h0007;
        b_in = 16'h0003;
        @(negedge clk);
        chk("s_mula1", mul_a, 4'd0);
        chk("s_mulb1", mul_b, 4'd9);
        wait_gnt(n);
        chk("s_gnt0", gnt, 4'b0001);
        chk("s_res0", result, 8'd0);
        req  = 4'b0100;
        a_in = 16'h0F00;
        b_in = 16'h0100;
        wait_gnt(n);
        chk("s_gnt2", gnt, 4'b0100);
        chk("s_res2", result, 8'd15);
        chk("s_id2", result_id, 2'd2);
        req = '0;
        @(negedge clk);
        chk("s_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
